// File: rtl/r2sdf_butterfly_stage.sv
// One R2SDF stage: drives the external DELAY-deep feedback register, emits scaled sums then differences.
// Output is registered with 1 cycle latency; there is no backpressure and every accepted block is consumed in full.
module r2sdf_butterfly_stage #(
    parameter int DELAY = 2,
    parameter int WIDTH = 17,
    parameter int CNT_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_r,
    input  logic signed [WIDTH-1:0] in_i,
    input  logic signed [WIDTH-1:0] sr_r,
    input  logic signed [WIDTH-1:0] sr_i,
    output logic signed [WIDTH-1:0] fb_r,
    output logic signed [WIDTH-1:0] fb_i,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_r,
    output logic signed [WIDTH-1:0] out_i,
    output logic                    out_sof
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL0 = 3'd1,
        BFLY  = 3'd2,
        FILL  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2*DELAY-1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DELAY-1);

    state_t                  st_q, st_d, eff_st;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                    out_valid_q, out_valid_d;
    logic                    out_sof_q, out_sof_d;
    logic signed [WIDTH-1:0] out_r_q, out_r_d;
    logic signed [WIDTH-1:0] out_i_q, out_i_d;

    // One extra bit of headroom so the halved result can never wrap.
    logic signed [WIDTH:0]   sum_r, sum_i, dif_r, dif_i;

    always_comb begin
        sum_r = {sr_r[WIDTH-1], sr_r} + {in_r[WIDTH-1], in_r};
        sum_i = {sr_i[WIDTH-1], sr_i} + {in_i[WIDTH-1], in_i};
        dif_r = {sr_r[WIDTH-1], sr_r} - {in_r[WIDTH-1], in_r};
        dif_i = {sr_i[WIDTH-1], sr_i} - {in_i[WIDTH-1], in_i};
    end

    always_comb begin
        // in_valid only matters at a block start: leaving IDLE, or cnt==0 after a BFLY.
        eff_st = st_q;
        if (st_q == IDLE && in_valid) begin
            eff_st = FILL0;
        end
        if (st_q == FILL && cnt_q == '0 && !in_valid) begin
            eff_st = DRAIN;
        end

        cnt_inc     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        st_d        = eff_st;
        cnt_d       = cnt_inc;
        fb_r        = '0;
        fb_i        = '0;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_r_d     = '0;
        out_i_d     = '0;

        unique case (eff_st)
            IDLE: begin
                cnt_d = '0;
            end
            FILL0: begin
                fb_r = in_r;
                fb_i = in_i;
                if (cnt_inc == CNT_HALF) st_d = BFLY;
            end
            FILL: begin
                fb_r        = in_r;
                fb_i        = in_i;
                out_valid_d = 1'b1;
                out_r_d     = sr_r;
                out_i_d     = sr_i;
                if (cnt_inc == CNT_HALF) st_d = BFLY;
            end
            BFLY: begin
                fb_r        = dif_r[WIDTH:1];
                fb_i        = dif_i[WIDTH:1];
                out_valid_d = 1'b1;
                out_sof_d   = (cnt_q == CNT_HALF);
                out_r_d     = sum_r[WIDTH:1];
                out_i_d     = sum_i[WIDTH:1];
                if (cnt_q == CNT_LAST) st_d = FILL;
            end
            DRAIN: begin
                out_valid_d = 1'b1;
                out_r_d     = sr_r;
                out_i_d     = sr_i;
                if (cnt_q == DRAIN_LAST) begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end
            end
            default: begin
                st_d  = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;

endmodule

// File: tb/tb_r2sdf_butterfly_stage.sv
// Scoreboard bench for r2sdf_butterfly_stage with a behavioural external feedback register.
module tb_r2sdf_butterfly_stage;

    localparam int D = 2;
    localparam int W = 17;
    localparam int CW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic signed [W-1:0] in_r, in_i, sr_r, sr_i, fb_r, fb_i, out_r, out_i;
    logic                out_valid, out_sof;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int r;
        int i;
        int sof;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   stim_r[$];
    int   stim_i[$];
    logic prev_vld = 1'b0;

    logic signed [W-1:0] sreg_r[D];
    logic signed [W-1:0] sreg_i[D];

    always #5 clk = ~clk;

    r2sdf_butterfly_stage #(.DELAY(D), .WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_r(in_r), .in_i(in_i), .sr_r(sr_r), .sr_i(sr_i),
        .fb_r(fb_r), .fb_i(fb_i), .out_valid(out_valid),
        .out_r(out_r), .out_i(out_i), .out_sof(out_sof)
    );

    // External feedback shift register, sharing the stage reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < D; k++) begin
                sreg_r[k] <= '0;
                sreg_i[k] <= '0;
            end
        end else begin
            sreg_r[0] <= fb_r;
            sreg_i[0] <= fb_i;
            for (int k = 1; k < D; k++) begin
                sreg_r[k] <= sreg_r[k-1];
                sreg_i[k] <= sreg_i[k-1];
            end
        end
    end
    assign sr_r = sreg_r[D-1];
    assign sr_i = sreg_i[D-1];

    task automatic chk(input string tag, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, expv, $time);
        end
    endtask

    function automatic int asr1(input int v);
        return v >>> 1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (prev_vld && exp_q.size() != 0) chk("continuity", int'(out_valid), 1);
            if (out_valid) begin
                chk("out_pending", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_r", int'(out_r), e.r);
                    chk("out_i", int'(out_i), e.i);
                    chk("out_sof", int'(out_sof), e.sof);
                end
            end
            prev_vld = out_valid;
        end else begin
            prev_vld = 1'b0;
        end
    end

    task automatic add(input int r, input int i);
        stim_r.push_back(r);
        stim_i.push_back(i);
    endtask

    // Queue expected sums then differences per block, then stream the samples.
    task automatic send(input int abort_idx);
        int n;
        int b;
        exp_t x;
        n = stim_r.size();
        for (int f = 0; f < n / (2*D); f++) begin
            b = f * 2 * D;
            for (int k = 0; k < D; k++) begin
                x.r   = asr1(stim_r[b+k] + stim_r[b+k+D]);
                x.i   = asr1(stim_i[b+k] + stim_i[b+k+D]);
                x.sof = (k == 0) ? 1 : 0;
                exp_q.push_back(x);
            end
            for (int k = 0; k < D; k++) begin
                x.r   = asr1(stim_r[b+k] - stim_r[b+k+D]);
                x.i   = asr1(stim_i[b+k] - stim_i[b+k+D]);
                x.sof = 0;
                exp_q.push_back(x);
            end
        end
        for (int s = 0; s < n; s++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_r     = stim_r[s][W-1:0];
            in_i     = stim_i[s][W-1:0];
            if (s == abort_idx) begin
                #6;
                rst = 1'b0;
                #1;
                chk("rst_async_vld", int'(out_valid), 0);
                chk("rst_async_r", int'(out_r), 0);
                chk("rst_async_i", int'(out_i), 0);
                exp_q.delete();
                in_valid = 1'b0;
                in_r     = '0;
                in_i     = '0;
                stim_r.delete();
                stim_i.delete();
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_r     = '0;
        in_i     = '0;
        stim_r.delete();
        stim_i.delete();
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
        chk({tag, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle_vld"}, int'(out_valid), 0);
        chk({tag, "_idle_fb_r"}, int'(fb_r), 0);
        chk({tag, "_idle_fb_i"}, int'(fb_i), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_r     = '0;
        in_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vld", int'(out_valid), 0);
        chk("reset_sof", int'(out_sof), 0);
        chk("reset_r", int'(out_r), 0);
        chk("reset_i", int'(out_i), 0);
        chk("reset_fb", int'(fb_r), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        add(100, 0); add(200, 0); add(300, 0); add(400, 0);
        send(-1);
        wait_idle("basic");

        for (int v = 1; v <= 8; v++) add(v, v);
        send(-1);
        wait_idle("b2b");

        add(1, 0); add(0, 0); add(0, 0); add(0, 0);
        send(-1);
        wait_idle("round_pos");

        add(0, 0); add(0, 0); add(1, 1); add(0, 0);
        send(-1);
        wait_idle("round_neg");

        for (int k = 0; k < 4; k++) add(-65536, -65536);
        send(-1);
        wait_idle("ext_min");

        add(65535, -65536); add(65535, 65535); add(-65536, 65535); add(-65536, -65536);
        send(-1);
        wait_idle("ext_mix");

        add(100, 0); add(200, 0); add(300, 0); add(400, 0);
        send(3);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_vld", int'(out_valid), 0);
            chk("post_rst_r", int'(out_r), 0);
            chk("post_rst_fb", int'(fb_r), 0);
        end

        add(100, 0); add(200, 0); add(300, 0); add(400, 0);
        send(-1);
        wait_idle("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/r2sdf_butterfly_stage.md
Name: r2sdf_butterfly_stage

Overview:
- Radix-2 single-path delay-feedback (R2SDF) butterfly and control for one stage of the 32-point FFT pipeline.
- Sits directly downstream of the 17-bit complex feedback shift register, which is external and has the same DELAY length. Drives that register's input and reads its output.
- Emits a continuous stream of scaled butterfly sums followed by differences to the next stage.

Parameters:
- DELAY, 2, feedback shift-register length. Equals half the butterfly span. Power of two, at least 1.
- WIDTH, 17, signed two's-complement width of each real/imag component.
- CNT_W, 2, counter width, equal to log2(2*DELAY).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_r, in_i  in  WIDTH each  input sample, real and imaginary, signed.
- sr_r, sr_i  in  WIDTH each  output of the external shift register.
- fb_r, fb_i  out  WIDTH each  combinational feed to the shift register input.
- out_valid  out  1  registered output valid.
- out_r, out_i  out  WIDTH each  registered stage output, signed.
- out_sof  out  1  registered; high on the first output sample of each 2*DELAY block.

Behaviour:
- Reset (rst low, async): state=IDLE, cnt=0. out_valid, out_sof, out_r, out_i all 0. The external shift register shares rst.
- The shift register advances every clk with no enable. fb presented in cycle t appears on sr in cycle t+DELAY.
- States:
  - IDLE: fb=0, so the register flushes zeros; output candidate invalid.
    - in_valid=1 → FILL0 with cnt=0, and the current sample is treated as the first sample of FILL0.
  - FILL0 (first block, cnt<DELAY): fb=in; output invalid.
  - BFLY (cnt≥DELAY):
    - sum = sign-extended (sr+in) at WIDTH+1 bits; out candidate = sum>>>1.
    - fb = ((sr−in) at WIDTH+1 bits)>>>1.
    - Candidate valid.
  - FILL (cnt<DELAY, after any BFLY): fb=in; out candidate = sr, which carries the previous differences; valid.
  - DRAIN: fb=0; out candidate = sr; valid for DELAY cycles, then → IDLE with cnt=0.
- cnt increments every cycle outside IDLE and wraps 2*DELAY−1 → 0.
  - When cnt wraps to 0 from BFLY: in_valid=1 → FILL; in_valid=0 → DRAIN.
  - cnt reaching DELAY moves FILL0/FILL → BFLY.
- in_valid is sampled only at block start (cnt=0). Once a block starts it is consumed as a full block regardless of in_valid; in is taken as-is.
- Scaling:
  - >>> is arithmetic shift, truncating toward −inf.
  - The WIDTH+1 intermediate means there is never overflow. −65536 + −65536 → −65536.
- Output register: out_* = candidate, registered, so latency is 1 cycle. Invalid candidates load 0 into out_r/out_i with out_valid=0.
- out_sof = 1 for the registered output of cycle cnt==DELAY in BFLY.
- End-to-end latency: sum of x[n] and x[n+DELAY] appears 1 cycle after x[n+DELAY] enters. The difference appears DELAY+1 cycles after that, order preserved.
- Back-to-back frames: FILL of frame k+1 outputs the differences of frame k, so output stays continuous with no bubble.
- Reset mid-operation: immediate return to IDLE and zeroed outputs. Partial frames are discarded. The shift register is cleared by the same rst.

Test Plan:
- DELAY=2, reset, then continuous inputs 100, 200, 300, 400 (imag 0), then in_valid=0:
  - out_r sequence 200, 300, −100, −100 on consecutive cycles, starting 1 cycle after 300 enters.
  - out_sof on 200 only; out_valid then falls and state returns to IDLE.
- Two frames back-to-back (1, 2, 3, 4, 5, 6, 7, 8 imag=real):
  - outputs 2, 3, −1, −1, 6, 7, −1, −1 for both real and imag.
  - out_valid continuous, with no gap between frames.
- Rounding with inputs 1, 0, 0, 0: sum (1+0)>>>1 = 0; difference (1−0)>>>1 = 0.
- Rounding with inputs 0, 0, 1, 0: difference (0−1)>>>1 = −1.
- Extremes with all inputs −65536: sums −65536, differences 0, no wrap. Repeat with +65535 and −65536 pairs: difference = 65535.
- Assert rst low during the second BFLY cycle:
  - out_valid, out_r and out_i go to 0 asynchronously.
  - After release with in_valid=0, outputs stay 0 and fb=0.
  - A fresh frame then reproduces scenario 1 exactly.
